// File: rtl/csr_access_ctrl.sv
// Register-access controller: latches one request, classifies it (ILLEGAL > PRIV > DECODE > OK),
// accesses a small register file and returns a response. Optional fault log: CSR_ACCESS_CTRL_TRAP_LOG_EN.
module csr_access_ctrl #(
    parameter logic [11:0] BASE_ADDR = 12'h060,
    parameter int          NUM_REGS  = 8,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_read,
    input  logic [11:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        priv_state,
    input  logic              except_i,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              trap_pending,
    output logic [11:0]       trap_addr,
    output logic              trap_is_write,
    output logic [1:0]        trap_priv,
    output logic [7:0]        trap_count,
    input  logic              trap_clear
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_PRIV    = 2'b01,
        ERR_DECODE  = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_e;

    typedef struct packed {
        logic              write;
        logic              read;
        logic [11:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        priv;
        logic              exc;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic [11:0]       off;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    err_e              cls;
    logic              exec_priv;

    // Addresses below the base wrap to large offsets, so one compare covers both bounds.
    assign off      = req_q.addr - BASE_ADDR;
    assign in_range = off < 12'(NUM_REGS);
    assign idx      = off[IDX_W-1:0];

    always_comb begin
        cls = ERR_OK;
        if (req_q.read && req_q.write)        cls = ERR_ILLEGAL;
        else if (!req_q.read && !req_q.write) cls = ERR_OK;
        else if (req_q.exc)                   cls = ERR_PRIV;
        else if (!in_range)                   cls = ERR_DECODE;
    end

    assign exec_priv = (state_q == S_EXEC) && (cls == ERR_PRIV);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        regs_d  = regs_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d   = '{write: req_write, read: req_read, addr: req_addr,
                                wdata: req_wdata, priv: priv_state, exc: except_i};
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                err_d   = cls;
                rdata_d = (cls == ERR_OK && req_q.read) ? regs_q[idx] : '0;
                if (cls == ERR_OK && req_q.write) regs_d[idx] = req_q.wdata;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = ERR_OK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            regs_q  <= '{default: '0};
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            regs_q  <= regs_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef CSR_ACCESS_CTRL_TRAP_LOG_EN
    logic        trap_pending_q, trap_pending_d;
    logic [11:0] trap_addr_q, trap_addr_d;
    logic        trap_is_write_q, trap_is_write_d;
    logic [1:0]  trap_priv_q, trap_priv_d;
    logic [7:0]  trap_count_q, trap_count_d;

    // Clear is applied first so a same-cycle fault lands on a clean log.
    always_comb begin
        trap_pending_d  = trap_pending_q;
        trap_addr_d     = trap_addr_q;
        trap_is_write_d = trap_is_write_q;
        trap_priv_d     = trap_priv_q;
        trap_count_d    = trap_count_q;
        if (trap_clear) begin
            trap_pending_d  = 1'b0;
            trap_addr_d     = '0;
            trap_is_write_d = 1'b0;
            trap_priv_d     = '0;
            trap_count_d    = '0;
        end
        if (exec_priv) begin
            if (!trap_pending_d) begin
                trap_addr_d     = req_q.addr;
                trap_is_write_d = req_q.write;
                trap_priv_d     = req_q.priv;
            end
            trap_pending_d = 1'b1;
            if (trap_count_d != 8'hFF) trap_count_d = trap_count_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_pending_q  <= 1'b0;
            trap_addr_q     <= '0;
            trap_is_write_q <= 1'b0;
            trap_priv_q     <= '0;
            trap_count_q    <= '0;
        end else begin
            trap_pending_q  <= trap_pending_d;
            trap_addr_q     <= trap_addr_d;
            trap_is_write_q <= trap_is_write_d;
            trap_priv_q     <= trap_priv_d;
            trap_count_q    <= trap_count_d;
        end
    end

    assign trap_pending  = trap_pending_q;
    assign trap_addr     = trap_addr_q;
    assign trap_is_write = trap_is_write_q;
    assign trap_priv     = trap_priv_q;
    assign trap_count    = trap_count_q;
`else
    logic unused_trap;
    assign unused_trap   = ^{trap_clear, exec_priv, req_q.priv};
    assign trap_pending  = 1'b0;
    assign trap_addr     = '0;
    assign trap_is_write = 1'b0;
    assign trap_priv     = '0;
    assign trap_count    = '0;
`endif

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the register file and fault log.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_read;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  priv_state;
    logic        except_i;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        trap_pending, trap_is_write, trap_clear;
    logic [11:0] trap_addr;
    logic [1:0]  trap_priv;
    logic [7:0]  trap_count;

    csr_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .priv_state(priv_state), .except_i(except_i),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .trap_pending(trap_pending), .trap_addr(trap_addr),
        .trap_is_write(trap_is_write), .trap_priv(trap_priv),
        .trap_count(trap_count), .trap_clear(trap_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [31:0] m_regs [8];
    logic        m_pend;
    logic [11:0] m_addr;
    logic        m_isw;
    logic [1:0]  m_priv;
    int          m_cnt;

    typedef struct {
        logic        w;
        logic        r;
        logic [11:0] a;
        logic [31:0] d;
        logic [1:0]  p;
        logic        e;
        logic [1:0]  err;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        model_clear();
    endtask

    task automatic model_clear();
        m_pend = 1'b0; m_addr = '0; m_isw = 1'b0; m_priv = '0; m_cnt = 0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                              input logic [1:0] p, input logic e,
                              output logic [1:0] err, output logic [31:0] rd);
        int off;
        off = int'(a) - 'h60;
        if (w && r)                err = 2'b11;
        else if (!w && !r)         err = 2'b00;
        else if (e)                err = 2'b01;
        else if (off < 0 || off > 7) err = 2'b10;
        else                       err = 2'b00;
        rd = '0;
        if (err == 2'b00 && r) rd = m_regs[off];
        if (err == 2'b00 && w) m_regs[off] = d;
        if (err == 2'b01) begin
            if (!m_pend) begin m_addr = a; m_isw = w; m_priv = p; end
            m_pend = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic chk_trap(input string nm);
`ifdef CSR_ACCESS_CTRL_TRAP_LOG_EN
        chk({nm, ".pending"}, 32'(trap_pending), 32'(m_pend));
        chk({nm, ".addr"},    32'(trap_addr),    32'(m_addr));
        chk({nm, ".is_write"},32'(trap_is_write),32'(m_isw));
        chk({nm, ".priv"},    32'(trap_priv),    32'(m_priv));
        chk({nm, ".count"},   32'(trap_count),   32'(m_cnt));
`else
        chk({nm, ".pending"}, 32'(trap_pending), 32'd0);
        chk({nm, ".addr"},    32'(trap_addr),    32'd0);
        chk({nm, ".is_write"},32'(trap_is_write),32'd0);
        chk({nm, ".priv"},    32'(trap_priv),    32'd0);
        chk({nm, ".count"},   32'(trap_count),   32'd0);
`endif
    endtask

    task automatic drive(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                         input logic [1:0] p, input logic e);
        req_write = w; req_read = r; req_addr = a; req_wdata = d; priv_state = p; except_i = e;
        req_valid = 1'b1;
    endtask

    // Full request/response with resp_ready held high; lat counts edges from accept to resp_valid.
    task automatic run_txn(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                           input logic [1:0] p, input logic e,
                           output logic [1:0] err, output logic [31:0] rd, output int lat);
        @(negedge clk);
        drive(w, r, a, d, p, e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no resp_valid expected resp_valid within 8 cycles");
        end
        err = resp_err;
        rd  = resp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk); trap_clear = 1'b1;
        @(negedge clk); trap_clear = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  err, e_err;
        logic [31:0] rd, e_rd, held;
        int          lat;

        tbl[0] = '{1, 0, 12'h063, 32'hDEADBEEF, 2'b11, 0, 2'b00, 32'h0};
        tbl[1] = '{0, 1, 12'h063, 32'h0,        2'b11, 0, 2'b00, 32'hDEADBEEF};
        tbl[2] = '{1, 0, 12'h064, 32'h12345678, 2'b00, 1, 2'b01, 32'h0};
        tbl[3] = '{0, 1, 12'h064, 32'h0,        2'b11, 0, 2'b00, 32'h0};
        tbl[4] = '{0, 1, 12'h070, 32'h0,        2'b11, 0, 2'b10, 32'h0};
        tbl[5] = '{1, 1, 12'h061, 32'h5,        2'b10, 1, 2'b11, 32'h0};
        tbl[6] = '{0, 0, 12'h070, 32'h0,        2'b10, 1, 2'b00, 32'h0};
        tbl[7] = '{0, 1, 12'h05F, 32'h0,        2'b11, 0, 2'b10, 32'h0};
        tbl[8] = '{1, 0, 12'h067, 32'hA5A5C3C3, 2'b11, 0, 2'b00, 32'h0};
        tbl[9] = '{0, 1, 12'h067, 32'h0,        2'b11, 0, 2'b00, 32'hA5A5C3C3};

        rst = 1'b1; req_valid = 0; req_write = 0; req_read = 0; req_addr = '0; req_wdata = '0;
        priv_state = '0; except_i = 0; resp_ready = 1'b1; trap_clear = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk_trap("rst.trap");
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].p, tbl[i].e, err, rd, lat);
            model_step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].p, tbl[i].e, e_err, e_rd);
            chk($sformatf("vec%0d.err", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("vec%0d.rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d.latency", i), 32'(lat), 32'd1);
        end
        chk_trap("vec.trap");

        // 256 PRIV reads: count saturates, first fault's fields stick
        pulse_clear();
        for (int i = 0; i < 256; i++) begin
            run_txn(0, 1, 12'h065, 32'h0, (i == 0) ? 2'b01 : 2'b10, 1, err, rd, lat);
            model_step(0, 1, 12'h065, 32'h0, (i == 0) ? 2'b01 : 2'b10, 1, e_err, e_rd);
            if (i == 255) chk("sat.err", 32'(err), 32'd1);
        end
`ifdef CSR_ACCESS_CTRL_TRAP_LOG_EN
        chk("sat.count", 32'(trap_count), 32'd255);
`else
        chk("sat.count", 32'(trap_count), 32'd0);
`endif
        chk_trap("sat.trap");

        // trap_clear coincident with an EXEC PRIV: new fault wins
        @(negedge clk);
        drive(1, 0, 12'h066, 32'h1, 2'b11, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; trap_clear = 1'b1;
        @(posedge clk); #1;
        trap_clear = 1'b0;
        model_clear();
        model_step(1, 0, 12'h066, 32'h1, 2'b11, 1, e_err, e_rd);
        chk("clrpriv.err", 32'(resp_err), 32'(e_err));
        chk_trap("clrpriv.trap");
        @(posedge clk); #1;
        pulse_clear();
        #1;
        chk_trap("clear.trap");

        // Backpressure: response held 5 cycles with req_valid still high
        @(negedge clk);
        drive(0, 1, 12'h063, 32'h0, 2'b11, 0);
        resp_ready = 1'b0;
        model_step(0, 1, 12'h063, 32'h0, 2'b11, 0, e_err, e_rd);
        held = e_rd;
        @(posedge clk); #1;
        chk("bp.exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d.rdata", i), resp_rdata, held);
            chk($sformatf("bp%0d.err", i), 32'(resp_err), 32'd0);
            chk($sformatf("bp%0d.ready", i), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.idle_ready", 32'(req_ready), 32'd1);
        chk("bp.idle_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp.reaccept", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        model_step(0, 1, 12'h063, 32'h0, 2'b11, 0, e_err, e_rd);
        @(posedge clk); #1;
        chk("bp.second_valid", 32'(resp_valid), 32'd1);
        chk("bp.second_rdata", resp_rdata, e_rd);
        @(posedge clk); #1;

        // Reset during EXEC of a write
        @(negedge clk);
        drive(1, 0, 12'h060, 32'hCAFEF00D, 2'b11, 0);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rstexec.ready", 32'(req_ready), 32'd1);
        chk("rstexec.valid", 32'(resp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstexec.no_resp", 32'(resp_valid), 32'd0);
        run_txn(0, 1, 12'h060, 32'h0, 2'b11, 0, err, rd, lat);
        model_step(0, 1, 12'h060, 32'h0, 2'b11, 0, e_err, e_rd);
        chk("rstexec.readback", rd, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic w, r, e;
            logic [1:0]  p;
            logic [11:0] a;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) == 0);
            p = 2'($urandom_range(0, 3));
            a = 12'h05C + 12'($urandom_range(0, 15));
            d = $urandom;
            run_txn(w, r, a, d, p, e, err, rd, lat);
            model_step(w, r, a, d, p, e, e_err, e_rd);
            chk($sformatf("rnd%0d.err", i), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d.rdata", i), rd, e_rd);
            if (i % 20 == 19) chk_trap($sformatf("rnd%0d.trap", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
